ps2_key_event: RTL and testbench

- Downstream consumer of the PS/2 receiver's 16-bit `code` output.
- Resynchronises `code` into the system clock domain and detects each new stable value.
- Classifies each new value as make, extended make, break or receive error.
- Queues the resulting key events in a small show-ahead FIFO with valid/ready handshake, for the display/control logic.

---
 rtl/ps2_defs.sv | 42 ++++
 rtl/ps2_evt_fifo.sv | 53 +++++
 rtl/ps2_key_event.sv | 78 +++++++
 tb/tb_ps2_key_event.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs.sv
// rtl/ps2_defs.sv - PS/2 key event constants, field layout and scan-code decode
package ps2_defs;

  localparam logic [7:0]  PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0]  PS2_PFX_BRK   = 8'hF0;
  localparam logic [15:0] PS2_CODE_ERR  = 16'hFFFF;
  localparam logic [15:0] PS2_CODE_IDLE = 16'h0000;

  localparam int PS2_EVT_KEY_LSB = 0;
  localparam int PS2_EVT_KEY_MSB = 7;
  localparam int PS2_EVT_EXT_BIT = 8;
  localparam int PS2_EVT_BRK_BIT = 9;
  localparam int PS2_EVT_ERR_BIT = 10;
  localparam int PS2_EVT_W       = 11;

  // Returns {push, event}; event = {err, brk, ext, key}.
  function automatic logic [PS2_EVT_W:0] ps2_decode(input logic [15:0] c);
    logic [7:0]           hi;
    logic [7:0]           lo;
    logic [PS2_EVT_W:0]   r;
    hi = c[15:8];
    lo = c[7:0];
    r  = '0;
    if (c == PS2_CODE_IDLE) begin
      r = '0;
    end else if (c == PS2_CODE_ERR) begin
      r[PS2_EVT_W]                       = 1'b1;
      r[PS2_EVT_ERR_BIT]                 = 1'b1;
      r[PS2_EVT_KEY_MSB:PS2_EVT_KEY_LSB] = 8'hFF;
    end else if (lo == PS2_PFX_EXT || lo == PS2_PFX_BRK) begin
      r = '0;
    end else begin
      r[PS2_EVT_W]                       = 1'b1;
      r[PS2_EVT_KEY_MSB:PS2_EVT_KEY_LSB] = lo;
      // E0 F0 xx arrives as {F0, xx}: extended breaks report ext=0.
      if (hi == PS2_PFX_BRK)      r[PS2_EVT_BRK_BIT] = 1'b1;
      else if (hi == PS2_PFX_EXT) r[PS2_EVT_EXT_BIT] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - generic synchronous show-ahead FIFO; full pushes dropped unless popping
module ps2_evt_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage is cleared too so the head outputs are never X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// rtl/ps2_key_event.sv - resync PS/2 code, detect new values, classify and queue key events
module ps2_key_event
  import ps2_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   code,
  input  logic          evt_ready,
  output logic          evt_valid,
  output logic [7:0]    evt_key,
  output logic          evt_ext,
  output logic          evt_break,
  output logic          evt_err,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  logic [15:0]          code_s1;
  logic [15:0]          code_s2;
  logic [15:0]          last;
  logic                 new_val;
  logic [PS2_EVT_W:0]   dec;
  logic                 push_q;
  logic [PS2_EVT_W-1:0] push_data;
  logic [PS2_EVT_W-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 pop;

  // Two equal sync samples mean the multi-bit code has settled.
  assign new_val = (code_s1 == code_s2) && (code_s2 != last);
  assign dec     = ps2_decode(code_s2);
  assign pop     = evt_ready && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_s1   <= '0;
      code_s2   <= '0;
      last      <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      overflow  <= 1'b0;
    end else begin
      code_s1   <= code;
      code_s2   <= code_s1;
      if (new_val) last <= code_s2;
      push_q    <= new_val && dec[PS2_EVT_W];
      push_data <= dec[PS2_EVT_W-1:0];
      if (push_q && full && !pop) overflow <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (push_data),
    .pop       (evt_ready),
    .rd_data   (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign evt_valid = !empty;
  assign evt_key   = head[PS2_EVT_KEY_MSB:PS2_EVT_KEY_LSB];
  assign evt_ext   = head[PS2_EVT_EXT_BIT];
  assign evt_break = head[PS2_EVT_BRK_BIT];
  assign evt_err   = head[PS2_EVT_ERR_BIT];

endmodule

// File: tb/tb_ps2_key_event.sv
// tb/tb_ps2_key_event.sv - directed self-checking bench for ps2_key_event
module tb_ps2_key_event;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] code;
  logic        evt_ready;
  logic        evt_valid;
  logic [7:0]  evt_key;
  logic        evt_ext;
  logic        evt_break;
  logic        evt_err;
  logic        overflow;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_key_event #(.DEPTH(4), .CW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_key    (evt_key),
    .evt_ext    (evt_ext),
    .evt_break  (evt_break),
    .evt_err    (evt_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] key, input logic ext,
                            input logic brk, input logic err);
    check({tag, ".valid"}, 32'(evt_valid), 32'd1);
    check({tag, ".key"},   32'(evt_key),   32'(key));
    check({tag, ".ext"},   32'(evt_ext),   32'(ext));
    check({tag, ".brk"},   32'(evt_break), 32'(brk));
    check({tag, ".err"},   32'(evt_err),   32'(err));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic hold(input logic [15:0] c, input int n);
    code = c;
    cycles(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int       n_ev;
    int       max_cnt;
    logic [3:0] brk_seq;
    logic [7:0] key_seq [4];

    rst_n     = 1'b0;
    code      = 16'h0000;
    evt_ready = 1'b0;
    cycles(2);
    check("rst.valid", 32'(evt_valid),  32'd0);
    check("rst.count", 32'(fifo_count), 32'd0);
    check("rst.key",   32'(evt_key),    32'd0);
    check("rst.ovf",   32'(overflow),   32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Latency: push lands on the 4th edge after the change.
    code = 16'h001C;
    cycles(3);
    check("lat.edge3", 32'(evt_valid), 32'd0);
    cycles(1);
    check_head("lat.edge4", 8'h1C, 1'b0, 1'b0, 1'b0);
    check("lat.count", 32'(fifo_count), 32'd1);
    cycles(20);
    check("repeat.count", 32'(fifo_count), 32'd1);
    pop_one();
    check("drain1.count", 32'(fifo_count), 32'd0);

    // Four event kinds queued then drained in order.
    do_reset();
    hold(16'h001C, 6);
    hold(16'hF01C, 6);
    hold(16'hE075, 6);
    hold(16'hFFFF, 6);
    check("seq.count", 32'(fifo_count), 32'd4);
    check_head("seq.make", 8'h1C, 1'b0, 1'b0, 1'b0);
    pop_one();
    check_head("seq.brk", 8'h1C, 1'b0, 1'b1, 1'b0);
    pop_one();
    check_head("seq.ext", 8'h75, 1'b1, 1'b0, 1'b0);
    pop_one();
    check_head("seq.err", 8'hFF, 1'b0, 1'b0, 1'b1);
    pop_one();
    check("seq.empty", 32'(fifo_count), 32'd0);

    // Prefix-only value produces nothing.
    hold(16'h00E0, 6);
    check("pfx.count", 32'(fifo_count), 32'd0);
    hold(16'hE06B, 6);
    check("pfx.count1", 32'(fifo_count), 32'd1);
    check_head("pfx.ext", 8'h6B, 1'b1, 1'b0, 1'b0);
    pop_one();

    // Fill, overflow, then push concurrent with pop while full.
    hold(16'h0011, 6);
    hold(16'h0012, 6);
    hold(16'h0013, 6);
    hold(16'h0014, 6);
    check("full.count", 32'(fifo_count), 32'd4);
    check("full.ovf0",  32'(overflow),   32'd0);
    hold(16'h0015, 6);
    check("ovf.flag",  32'(overflow),   32'd1);
    check("ovf.count", 32'(fifo_count), 32'd4);
    check("ovf.head",  32'(evt_key),    32'h11);
    code = 16'h0016;
    cycles(3);
    evt_ready = 1'b1;
    cycles(1);
    evt_ready = 1'b0;
    check("pp.count", 32'(fifo_count), 32'd4);
    check("pp.ovf",   32'(overflow),   32'd1);
    check_head("pp.h0", 8'h12, 1'b0, 1'b0, 1'b0);
    pop_one();
    check("pp.h1", 32'(evt_key), 32'h13);
    pop_one();
    check("pp.h2", 32'(evt_key), 32'h14);
    pop_one();
    check("pp.h3", 32'(evt_key), 32'h16);
    pop_one();
    check("pp.empty", 32'(fifo_count), 32'd0);

    // Streaming with evt_ready held high.
    evt_ready = 1'b1;
    n_ev      = 0;
    max_cnt   = 0;
    brk_seq   = '0;
    for (int i = 0; i < 4; i++) begin
      code = (i % 2 == 0) ? 16'h0029 : 16'hF029;
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (evt_valid && n_ev < 4) begin
          brk_seq[n_ev] = evt_break;
          key_seq[n_ev] = evt_key;
          n_ev++;
        end
      end
    end
    evt_ready = 1'b0;
    check("stream.nev",  32'(n_ev),    32'd4);
    check("stream.max",  32'(max_cnt), 32'd1);
    check("stream.brk",  32'(brk_seq), 32'b1010);
    check("stream.key0", 32'(key_seq[0]), 32'h29);
    check("stream.key3", 32'(key_seq[3]), 32'h29);

    // Asynchronous reset mid-stream with events queued.
    hold(16'h0031, 6);
    hold(16'h0032, 6);
    hold(16'h0033, 6);
    check("ar.count", 32'(fifo_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("ar.valid", 32'(evt_valid),  32'd0);
    check("ar.count0", 32'(fifo_count), 32'd0);
    check("ar.key",   32'(evt_key),    32'd0);
    check("ar.ovf",   32'(overflow),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    check("ar.edge3", 32'(evt_valid), 32'd0);
    cycles(1);
    check_head("ar.fresh", 8'h33, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
